// File: rtl/universal_shift_reg_p.sv
// Parametrised universal shift register with multi-cycle shift/rotate under a start/busy/done handshake.
// Optional adder on op 110 is enabled by defining USR_ADD_EN; otherwise op 110 acts as hold.
module universal_shift_reg_p #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [AMT_W-1:0] i_amt,
    input  logic [WIDTH-1:0] i_d_in,
    input  logic             i_ser_in,
    output logic [WIDTH-1:0] o_d_out,
    output logic             o_carry,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [AMT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_data;
    logic               r_carry;
    logic               r_busy;
    logic               r_done;

    logic               w_is_shift;
    logic [WIDTH-1:0]   w_step_data;
    logic               w_step_carry;

    assign w_is_shift = (i_op == OP_SHR) || (i_op == OP_SHL) ||
                        (i_op == OP_ROR) || (i_op == OP_ROL);

`ifdef USR_ADD_EN
    logic [WIDTH:0] w_sum;
    assign w_sum = {1'b0, r_data} + {1'b0, i_d_in};
`endif

    // One single-bit step of the latched shift/rotate; carry is the bit leaving the word.
    always_comb begin
        w_step_data  = r_data;
        w_step_carry = r_carry;
        case (r_op)
            OP_SHR: begin
                w_step_data  = {i_ser_in, r_data[WIDTH-1:1]};
                w_step_carry = r_data[0];
            end
            OP_SHL: begin
                w_step_data  = {r_data[WIDTH-2:0], i_ser_in};
                w_step_carry = r_data[WIDTH-1];
            end
            OP_ROR: begin
                w_step_data  = {r_data[0], r_data[WIDTH-1:1]};
                w_step_carry = r_data[0];
            end
            OP_ROL: begin
                w_step_data  = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                w_step_carry = r_data[WIDTH-1];
            end
            default: begin
                w_step_data  = r_data;
                w_step_carry = r_carry;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_HOLD;
            r_cnt   <= '0;
            r_data  <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        if (w_is_shift && (i_amt != '0)) begin
                            r_op    <= i_op;
                            r_cnt   <= i_amt;
                            r_busy  <= 1'b1;
                            r_state <= S_SHIFT;
                        end else begin
                            r_done <= 1'b1;
                            case (i_op)
                                OP_LOAD: r_data <= i_d_in;
                                OP_CLR: begin
                                    r_data  <= '0;
                                    r_carry <= 1'b0;
                                end
`ifdef USR_ADD_EN
                                OP_ADD: {r_carry, r_data} <= w_sum;
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                S_SHIFT: begin
                    r_data  <= w_step_data;
                    r_carry <= w_step_carry;
                    r_cnt   <= r_cnt - AMT_W'(1);
                    // Final step: drop busy and raise done for the following cycle.
                    if (r_cnt == AMT_W'(1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_d_out = r_data;
    assign o_carry = r_carry;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: doc/universal_shift_reg_p.md
# universal_shift_reg_p

Parametrised universal shift register, the next generation of the team's fixed 4-bit select-driven register. It adds generic width, a multi-position shift/rotate executed one bit per clock under a start/busy/done handshake, a serial fill input, and a carry/shift-out flag. It sits in the sequential-circuits datapath library as the working register for ALU and serial-conversion exercises.

## Interface
- WIDTH, 8, data width in bits (≥2)
- AMT_W, 3, width of the shift-amount input; amounts 0..2^AMT_W-1 are legal
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  command strobe; accepted only on a rising edge where busy=0
- op  in  3  opcode, sampled at accept
- amt  in  AMT_W  shift/rotate count, sampled at accept
- d_in  in  WIDTH  parallel operand, sampled at accept (load/add only)
- ser_in  in  1  serial fill bit for logical shifts, sampled live on every shift edge
- d_out  out  WIDTH  register contents
- carry  out  1  last bit shifted/rotated out, or adder carry
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle completion pulse

## Operation
- Opcodes: 000 hold; 001 parallel load d_in; 010 logical shift right, MSB filled with ser_in; 011 logical shift left, LSB filled with ser_in; 100 rotate right; 101 rotate left; 110 add (see Configuration); 111 clear (d_out=0, carry=0).
- FSM states: IDLE, SHIFT.
- IDLE, start=1, op in {000,001,110,111}, or op in 010..101 with amt=0: result is written at the accept edge, state stays IDLE, done=1 for the following cycle. Hold and amt=0 leave d_out and carry unchanged.
- IDLE, start=1, op in 010..101, amt=n>0: at the accept edge, latch op and set counter=n and busy=1. Do not modify d_out. Go to SHIFT.
- SHIFT: each edge performs one single-bit step and decrements the counter. carry takes the bit leaving the word (LSB for right, MSB for left; for rotates this is the bit that wraps). On the edge where the counter reaches 0, go to IDLE with busy=0 and done=1 for the next cycle.
- start is ignored while busy=1. op, amt and d_in may change freely during SHIFT.
- Add: {carry, d_out} <= {1'b0, d_out} + {1'b0, d_in}, computed WIDTH+1 bits wide; the sum wraps modulo 2^WIDTH.

## Timing
- Reset (async, any time including mid-SHIFT): d_out=0, carry=0, busy=0, done=0, counter=0, state IDLE. The first accept is possible on the first rising edge after reset deasserts.
- Latency from the accept edge: single-cycle ops update at that edge, and done is high in cycle k+1. A shift of n updates at edges k+1..k+n, busy is high in cycles k+1..k+n, and done is high in cycle k+n+1.
- done and busy are never high together. A new start may be accepted in the same cycle that done is high (back-to-back).
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- USR_ADD_EN defined: op 110 performs the WIDTH+1-bit add described above.
- USR_ADD_EN undefined: the adder is not synthesised. op 110 behaves as hold (no change to d_out or carry), and done still pulses in the next cycle.

## Test plan
- Reset: assert reset mid-run → d_out=0x00, carry=0, busy=0, done=0 immediately and without a clock edge.
- Load 0xA5, then op 010, amt=3, ser_in=1 → busy high for 3 cycles, with intermediate values 0xD2/c1, 0xE9/c0 and final value 0xF4, carry=1; done pulses once.
- Load 0x3C, then op 101, amt=4 → d_out=0xC3, carry=1; busy high for 4 cycles; a start pulse with op 111 issued during busy has no effect.
- Load 0xF0, then op 110 with d_in=0x20 → with USR_ADD_EN: d_out=0x10, carry=1. Without it: d_out=0xF0, carry unchanged. done pulses in both cases.
- op 011, amt=0 → d_out unchanged, busy stays 0, done pulses in the next cycle. A back-to-back start with op 111, issued in the done cycle, is accepted: d_out=0x00, carry=0.
- Assert reset two cycles into an amt=5 shift → the shift aborts, d_out=0x00. After release, a load of 0x5A is accepted on the first edge.
